// File: rtl/dmem_arbiter.sv
// Data memory arbiter: CPU MEM stage vs DMA/debug burst port.
// CPU wins by default; a blocked DMA request is forced through after a bounded wait.
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic              cpu_byte_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_start_addr,
  input  logic              dma_valid,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_ready,
  output logic              dma_grant,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_done,
  output logic              mem_write,
  output logic              mem_byte_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [BW-1:0]     beat_cnt;
  logic [WW-1:0]     wait_cnt;

  logic beat;
  logic final_beat;
  logic starved;

  assign dma_grant  = (state == BURST);
  assign dma_ready  = dma_grant;
  assign cpu_rdata  = mem_read_data;
  assign cpu_stall  = dma_grant & cpu_req;
  assign beat       = dma_valid & dma_grant;
  assign final_beat = beat & (dma_last |
                      (beat_cnt == BW'(MAX_BURST - 1)));
  assign starved    = (wait_cnt == WW'(STARVE_LIMIT - 1));

  // Memory port mux: burst owner drives word beats, otherwise the CPU passes through
  always_comb begin
    mem_address    = cpu_addr;
    mem_write_data = cpu_wdata;
    mem_byte_en    = cpu_byte_en;
    mem_write      = cpu_req & cpu_write;
    if (dma_grant) begin
      mem_address    = addr_q;
      mem_write_data = dma_wdata;
      mem_byte_en    = 1'b0;
      mem_write      = dma_valid & write_q;
    end
  end

  // Arbitration FSM with burst address/beat tracking and registered DMA responses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      beat_cnt   <= '0;
      wait_cnt   <= '0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dma_req) begin
            if (!cpu_req || starved) begin
              state    <= BURST;
              addr_q   <= dma_start_addr;
              write_q  <= dma_write;
              beat_cnt <= '0;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        BURST: begin
          if (beat) begin
            addr_q   <= addr_q + ADDR_W'(2);
            beat_cnt <= beat_cnt + BW'(1);
            if (!write_q) begin
              dma_rdata  <= mem_read_data;
              dma_rvalid <= 1'b1;
            end
            if (final_beat) begin
              state    <= COOL;
              dma_done <= 1'b1;
            end
          end else if (!dma_req) begin
            state <= COOL;
          end
        end
        COOL: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, then random bursts
// checked against arbitration rules and a behavioural memory.
module tb_dmem_arbiter;

  localparam int STARVE = 4;
  localparam int MAXB   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req, cpu_write, cpu_byte_en;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_write, dma_valid, dma_last;
  logic [15:0] dma_start_addr, dma_wdata, dma_rdata;
  logic        dma_ready, dma_grant, dma_rvalid, dma_done;
  logic        mem_write, mem_byte_en;
  logic [15:0] mem_address, mem_write_data, mem_read_data;

  logic [15:0] mem [0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_byte_en(cpu_byte_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .dma_req(dma_req),
    .dma_write(dma_write), .dma_start_addr(dma_start_addr),
    .dma_valid(dma_valid), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_ready(dma_ready),
    .dma_grant(dma_grant), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .mem_write(mem_write), .mem_byte_en(mem_byte_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_address[15:1]] <= mem_write_data;
  end

  assign mem_read_data = mem[mem_address[15:1]];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a[15:1]; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic quiet();
    cpu_req = 0; cpu_write = 0; cpu_byte_en = 0;
    cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 0; dma_write = 0; dma_start_addr = 16'h0;
    dma_valid = 0; dma_wdata = 16'h0; dma_last = 0;
  endtask

  initial begin
    logic [15:0] st, a, exp_rd;
    logic        wr, v, fin, granted;
    int          len, nb, blocked;

    // ---- reset with both requesters active
    quiet();
    cpu_req = 1; cpu_write = 1; cpu_addr = 16'h1234;
    cpu_wdata = 16'h00AA; cpu_byte_en = 1; dma_req = 1;
    #2;
    chk("rst_grant", dma_grant, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_addr", mem_address, 16'h1234);
    chk("rst_we", mem_write, 1);
    chk("rst_be", mem_byte_en, 1);
    tick(); tick();
    chk("rst_grant_hold", dma_grant, 0);
    quiet();
    reset = 1'b1;
    tick();

    // ---- DMA write burst alone
    preload(16'h0104, 16'h0000);
    dma_req = 1; dma_write = 1; dma_start_addr = 16'h0100;
    tick();
    chk("w_grant", dma_grant, 1);
    chk("w_ready", dma_ready, 1);
    dma_start_addr = 16'h7770; dma_write = 0;
    for (int i = 0; i < 3; i++) begin
      dma_valid = 1; dma_wdata = 16'hA000 + 16'(i);
      dma_last = (i == 2);
      #1;
      chk("w_addr", mem_address, 16'h0100 + 16'(2 * i));
      chk("w_we", mem_write, 1);
      chk("w_data", mem_write_data, 16'hA000 + 16'(i));
      chk("w_be", mem_byte_en, 0);
      tick();
      if (i < 2) chk("w_nodone", dma_done, 0);
    end
    chk("w_done", dma_done, 1);
    chk("w_cool_grant", dma_grant, 0);
    dma_valid = 0; dma_last = 0;
    chk("w_mem0", mem[16'h0080], 16'hA000);
    chk("w_mem2", mem[16'h0082], 16'hA002);
    tick();
    chk("w_done_pulse", dma_done, 0);
    chk("w_idle_grant", dma_grant, 0);
    tick();
    chk("w_regrant", dma_grant, 1);
    dma_req = 0;
    tick();
    chk("abort_grant", dma_grant, 0);
    chk("abort_done", dma_done, 0);
    tick();

    // ---- starvation: CPU holds the port
    preload(16'h0300, 16'h5A5A);
    cpu_req = 1; cpu_write = 0; cpu_addr = 16'h2000;
    dma_req = 1; dma_write = 0; dma_start_addr = 16'h0300;
    for (int c = 1; c <= STARVE; c++) begin
      #1;
      chk("st_grant", dma_grant, 0);
      chk("st_stall", cpu_stall, 0);
      chk("st_addr", mem_address, 16'h2000);
      tick();
    end
    chk("st_forced", dma_grant, 1);
    chk("st_stall_burst", cpu_stall, 1);
    dma_valid = 1; dma_last = 1;
    #1;
    chk("st_beat_addr", mem_address, 16'h0300);
    chk("st_beat_we", mem_write, 0);
    tick();
    chk("st_rvalid", dma_rvalid, 1);
    chk("st_rdata", dma_rdata, 16'h5A5A);
    chk("st_done", dma_done, 1);
    chk("st_cool_stall", cpu_stall, 0);
    quiet();
    tick();
    chk("st_rvalid_pulse", dma_rvalid, 0);

    // ---- burst cap without dma_last
    dma_req = 1; dma_write = 1; dma_start_addr = 16'h0000;
    tick();
    chk("cap_grant", dma_grant, 1);
    for (int i = 0; i < MAXB; i++) begin
      dma_valid = 1; dma_wdata = 16'hC000 + 16'(i);
      #1;
      chk("cap_addr", mem_address, 16'(2 * i));
      tick();
      if (i < MAXB - 1) chk("cap_in_burst", dma_grant, 1);
    end
    chk("cap_exit", dma_grant, 0);
    chk("cap_done", dma_done, 1);
    chk("cap_addr_q", dut.addr_q, 16'h0010);
    quiet();
    tick();

    // ---- wrap and read
    preload(16'hFFFE, 16'hBEEF);
    preload(16'h0000, 16'h1357);
    dma_req = 1; dma_write = 0; dma_start_addr = 16'hFFFE;
    tick();
    dma_valid = 1;
    #1;
    chk("wr_addr0", mem_address, 16'hFFFE);
    chk("wr_we0", mem_write, 0);
    tick();
    chk("wr_rvalid0", dma_rvalid, 1);
    chk("wr_rdata0", dma_rdata, 16'hBEEF);
    dma_valid = 0;
    tick();
    chk("wr_rvalid_gap", dma_rvalid, 0);
    dma_valid = 1; dma_last = 1;
    #1;
    chk("wr_addr1", mem_address, 16'h0000);
    tick();
    chk("wr_rvalid1", dma_rvalid, 1);
    chk("wr_rdata1", dma_rdata, 16'h1357);
    chk("wr_done", dma_done, 1);
    quiet();
    tick();

    // ---- reset in the middle of a write burst
    preload(16'h0404, 16'hDEAD);
    dma_req = 1; dma_write = 1; dma_start_addr = 16'h0400;
    tick();
    for (int i = 0; i < 2; i++) begin
      dma_valid = 1; dma_wdata = 16'h1110 + 16'(i);
      tick();
    end
    dma_wdata = 16'h9999;
    #1;
    reset = 1'b0;
    #1;
    chk("mr_grant", dma_grant, 0);
    chk("mr_we", mem_write, 0);
    chk("mr_done", dma_done, 0);
    tick();
    chk("mr_done_hold", dma_done, 0);
    chk("mr_rvalid", dma_rvalid, 0);
    quiet();
    reset = 1'b1;
    tick();
    chk("mr_idle", dma_grant, 0);
    chk("mr_no_done", dma_done, 0);
    chk("mr_mem_kept", mem[16'h0202], 16'hDEAD);
    chk("mr_mem_b1", mem[16'h0201], 16'h1111);

    // ---- random bursts against rule-level expectations
    for (int b = 0; b < 30; b++) begin
      st = 16'($urandom); st[0] = 1'b0;
      wr = 1'($urandom);
      len = $urandom_range(1, 10);
      dma_req = 1; dma_write = wr; dma_start_addr = st;
      dma_valid = 0; dma_last = 0;
      blocked = 0; granted = 0;
      for (int c = 0; c < 2 * STARVE && !granted; c++) begin
        cpu_req = 1'($urandom); cpu_write = 1'($urandom);
        cpu_byte_en = 1'($urandom);
        cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        #1;
        chk("rnd_pre_grant", dma_grant, 0);
        chk("rnd_cpu_addr", mem_address, cpu_addr);
        chk("rnd_cpu_we", mem_write, cpu_req & cpu_write);
        chk("rnd_cpu_stall", cpu_stall, 0);
        granted = !cpu_req || (blocked == STARVE - 1);
        if (cpu_req) blocked++;
        tick();
      end
      chk("rnd_grant", dma_grant, 1);
      dma_start_addr = 16'($urandom); dma_write = ~wr;
      nb = 0; fin = 0;
      for (int c = 0; c < 60 && !fin; c++) begin
        cpu_req = 1'($urandom); cpu_addr = 16'($urandom);
        cpu_write = 1'($urandom);
        dma_valid = ($urandom_range(0, 3) != 0);
        dma_wdata = 16'($urandom);
        dma_last = dma_valid && (nb == len - 1);
        #1;
        chk("rnd_stall", cpu_stall, cpu_req);
        chk("rnd_ready", dma_ready, 1);
        v = dma_valid;
        exp_rd = 16'h0;
        if (v) begin
          a = st + 16'(2 * nb);
          chk("rnd_beat_addr", mem_address, a);
          chk("rnd_beat_we", mem_write, wr);
          chk("rnd_beat_be", mem_byte_en, 0);
          if (wr) chk("rnd_beat_wd", mem_write_data, dma_wdata);
          else exp_rd = mem[a[15:1]];
          fin = (nb == len - 1) || (nb == MAXB - 1);
          nb++;
        end else begin
          chk("rnd_idle_we", mem_write, 0);
        end
        tick();
        chk("rnd_rvalid", dma_rvalid, v && !wr);
        if (v && !wr) chk("rnd_rdata", dma_rdata, exp_rd);
        chk("rnd_done", dma_done, fin);
      end
      chk("rnd_exit", dma_grant, 0);
      quiet();
      tick();
      chk("rnd_cool_exit", dma_grant, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
